dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 109 ++++++++++
 tb/tb_dma_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// Single-channel word DMA: moves cfg_len 32-bit words from cfg_src to cfg_dst,
// one read/write pair at a time, then raises a level interrupt until irq_clr.
module dma_ctrl #(
  parameter int LEN_BITS = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cfg_start,
  input  logic [31:0]         cfg_src,
  input  logic [31:0]         cfg_dst,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                irq_clr,
  output logic                busy,
  output logic                done_irq,
  output logic                R_req,
  output logic [31:0]         DMA_R_ADDR,
  input  logic [31:0]         DMA_R_DATA,
  input  logic                R_valid,
  output logic                W_req,
  output logic [31:0]         DMA_W_ADDR,
  output logic [31:0]         DMA_W_DATA,
  input  logic                W_done,
  output logic [2:0]          dbg_state
);

  // Request/response: R_req and W_req are single-cycle pulses; the master stage
  // answers with a single-cycle R_valid / W_done, which only counts in the
  // matching wait state. Addresses hold steady until that answer arrives.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [31:0]         buf_q, buf_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          src_d   = {cfg_src[31:2], 2'b00};
          dst_d   = {cfg_dst[31:2], 2'b00};
          rem_d   = cfg_len;
          state_d = (cfg_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (R_valid) begin
          buf_d   = DMA_R_DATA;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ:  state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        // Pointers wrap modulo 2^32 through plain 32-bit addition.
        if (W_done) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - LEN_BITS'(1);
          state_d = (rem_q == LEN_BITS'(1)) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        if (irq_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign R_req      = (state_q == S_RD_REQ);
  assign W_req      = (state_q == S_WR_REQ);
  assign busy       = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                      (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign done_irq   = (state_q == S_DONE);
  assign DMA_R_ADDR = src_q;
  assign DMA_W_ADDR = dst_q;
  assign DMA_W_DATA = buf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: a latency-programmable master-stage responder plus an
// address/data reference model built from the transfer rules.
module tb_dma_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_start;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        irq_clr;
  logic        busy, done_irq;
  logic        r_req, w_req;
  logic [31:0] dma_r_addr, dma_w_addr, dma_w_data;
  logic [31:0] r_data;
  logic        r_valid, r_valid_resp, r_valid_tb;
  logic        w_done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // Responder controls and observations.
  bit  resp_en = 0;
  int  rd_lat = 1, wr_lat = 1;
  int  overlap_cnt = 0, stab_bad = 0;
  logic [31:0] rd_obs_q[$], wr_obs_q[$], wd_obs_q[$];
  logic [31:0] exp_data_q[$], exp_rd_q[$], exp_wr_q[$];

  assign r_valid = r_valid_resp | r_valid_tb;

  always #5 aclk = ~aclk;

  dma_ctrl #(.LEN_BITS(16)) dut (
    .ACLK(aclk), .ARESETn(aresetn), .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len), .irq_clr(irq_clr), .busy(busy),
    .done_irq(done_irq), .R_req(r_req), .DMA_R_ADDR(dma_r_addr),
    .DMA_R_DATA(r_data), .R_valid(r_valid), .W_req(w_req),
    .DMA_W_ADDR(dma_w_addr), .DMA_W_DATA(dma_w_data), .W_done(w_done),
    .dbg_state(dbg_state)
  );

  // Master-stage model: answers each request rd_lat / wr_lat cycles later.
  initial begin : responder
    int rd_cnt, wr_cnt;
    bit rd_pend, wr_pend;
    logic [31:0] rd_req_addr, wr_req_addr;
    rd_cnt = 0; wr_cnt = 0; rd_pend = 0; wr_pend = 0;
    rd_req_addr = '0; wr_req_addr = '0;
    r_valid_resp = 1'b0; w_done = 1'b0; r_data = '0;
    forever begin
      @(negedge aclk);
      r_valid_resp = 1'b0;
      w_done = 1'b0;
      if (r_req === 1'b1 && w_req === 1'b1) overlap_cnt++;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_pend = 0;
          r_data = $urandom;
          r_valid_resp = 1'b1;
          exp_data_q.push_back(r_data);
          if (dma_r_addr !== rd_req_addr) stab_bad++;
        end
      end
      if (wr_pend) begin
        wr_cnt--;
        if (wr_cnt == 0) begin
          wr_pend = 0;
          w_done = 1'b1;
          if (dma_w_addr !== wr_req_addr) stab_bad++;
        end
      end
      if (r_req === 1'b1) begin
        rd_obs_q.push_back(dma_r_addr);
        rd_req_addr = dma_r_addr;
        if (resp_en) begin rd_pend = 1; rd_cnt = rd_lat; end
      end
      if (w_req === 1'b1) begin
        wr_obs_q.push_back(dma_w_addr);
        wd_obs_q.push_back(dma_w_data);
        wr_req_addr = dma_w_addr;
        if (resp_en) begin wr_pend = 1; wr_cnt = wr_lat; end
      end
    end
  end

  // Reference model: word i is read at aligned(src)+4i and written at aligned(dst)+4i.
  function automatic void build_model(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] s, d;
    exp_rd_q.delete();
    exp_wr_q.delete();
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      exp_rd_q.push_back(s + 32'(4 * i));
      exp_wr_q.push_back(d + 32'(4 * i));
    end
  endfunction

  // One complete transfer followed by irq_clr; disturb pokes cfg_start and
  // irq_clr while busy and cfg_start again while in DONE.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int rlat, input int wlat, input bit disturb, input string tag);
    int cyc, exp_cyc, busy_bad, ov0, sb0;
    rd_lat = rlat; wr_lat = wlat; resp_en = 1;
    rd_obs_q.delete(); wr_obs_q.delete(); wd_obs_q.delete(); exp_data_q.delete();
    build_model(src, dst, len);
    ov0 = overlap_cnt; sb0 = stab_bad; busy_bad = 0;
    exp_cyc = len * (2 + rlat + wlat) + 1;
    cfg_src = src; cfg_dst = dst; cfg_len = 16'(len); cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    cyc = 1;
    while (done_irq !== 1'b1 && cyc < 2000) begin
      if (busy !== 1'b1) busy_bad++;
      if (disturb && cyc == 2) begin
        cfg_start = 1'b1; irq_clr = 1'b1;
        cfg_src = ~src; cfg_dst = ~dst; cfg_len = 16'd7;
      end else begin
        cfg_start = 1'b0; irq_clr = 1'b0;
      end
      @(negedge aclk);
      cyc++;
    end
    cfg_start = 1'b0; irq_clr = 1'b0;
    checks++;
    if (cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s done_latency: got=%0d cycles exp=%0d", tag, cyc, exp_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy_during_xfer: low_cycles=%0d exp=0", tag, busy_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_in_done: got=%b exp=0", tag, busy);
    end
    if (disturb) begin
      cfg_start = 1'b1; cfg_src = 32'h0BAD_0000; cfg_len = 16'd3;
      @(negedge aclk);
      cfg_start = 1'b0;
      repeat (2) @(negedge aclk);
    end else begin
      @(negedge aclk);
    end
    checks++;
    if (done_irq !== 1'b1) begin
      failures++;
      $display("FAIL %s done_irq_hold: got=%b exp=1", tag, done_irq);
    end
    irq_clr = 1'b1;
    @(negedge aclk);
    irq_clr = 1'b0;
    checks++;
    if (done_irq !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s irq_clr_to_idle: done_irq=%b busy=%b exp 0/0", tag, done_irq, busy);
    end
    checks++;
    if (rd_obs_q.size() != len || wr_obs_q.size() != len) begin
      failures++;
      $display("FAIL %s request_count: reads=%0d writes=%0d exp=%0d", tag,
               rd_obs_q.size(), wr_obs_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        checks++;
        if (rd_obs_q[i] !== exp_rd_q[i] || wr_obs_q[i] !== exp_wr_q[i] ||
            wd_obs_q[i] !== exp_data_q[i]) begin
          failures++;
          $display("FAIL %s word%0d: rd=%h/%h wr=%h/%h data=%h/%h (got/exp)", tag, i,
                   rd_obs_q[i], exp_rd_q[i], wr_obs_q[i], exp_wr_q[i], wd_obs_q[i], exp_data_q[i]);
        end
      end
    end
    checks++;
    if (overlap_cnt != ov0 || stab_bad != sb0) begin
      failures++;
      $display("FAIL %s handshake_rules: overlaps=%0d unstable_addr=%0d exp 0/0", tag,
               overlap_cnt - ov0, stab_bad - sb0);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (r_req !== 1'b0 || w_req !== 1'b0 || busy !== 1'b0 || done_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: r_req=%b w_req=%b busy=%b done_irq=%b exp all 0",
               r_req, w_req, busy, done_irq);
    end
    checks++;
    if (dma_r_addr !== 32'h0 || dma_w_addr !== 32'h0 || dma_w_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: r_addr=%h w_addr=%h w_data=%h exp all 0",
               dma_r_addr, dma_w_addr, dma_w_data);
    end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || done_irq !== 1'b0 || r_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done_irq=%b r_req=%b exp 0", busy, done_irq, r_req);
    end
  endtask

  task automatic test_basic();
    run_xfer(32'h0000_1000, 32'h0000_2000, 3, 2, 2, 1'b0, "basic");
  endtask

  task automatic test_len_zero();
    run_xfer(32'h0000_4000, 32'h0000_5000, 0, 1, 1, 1'b0, "len_zero");
  endtask

  task automatic test_align();
    run_xfer(32'h0000_1003, 32'h0000_2002, 1, 1, 1, 1'b0, "align");
    run_xfer(32'hFFFF_FFFC, 32'h0000_8000, 2, 1, 2, 1'b0, "wrap");
  endtask

  task automatic test_start_ignored();
    run_xfer(32'h0000_7000, 32'h0000_9000, 2, 3, 2, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid();
    int reqs, irqs, busys;
    resp_en = 0;
    rd_obs_q.delete(); wr_obs_q.delete(); wd_obs_q.delete();
    cfg_src = 32'h0000_3000; cfg_dst = 32'h0000_6000; cfg_len = 16'd4; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    checks++;
    if (r_req !== 1'b0 || w_req !== 1'b0 || busy !== 1'b0 || done_irq !== 1'b0 ||
        dma_r_addr !== 32'h0 || dma_w_addr !== 32'h0 || dma_w_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: r_req=%b w_req=%b busy=%b irq=%b ra=%h wa=%h wd=%h exp all 0",
               r_req, w_req, busy, done_irq, dma_r_addr, dma_w_addr, dma_w_data);
    end
    aresetn = 1'b1;
    r_valid_tb = 1'b1;
    r_data = 32'hDEAD_BEEF;
    @(negedge aclk);
    r_valid_tb = 1'b0;
    reqs = 0; irqs = 0; busys = 0;
    repeat (10) begin
      if (r_req === 1'b1 || w_req === 1'b1) reqs++;
      if (done_irq === 1'b1) irqs++;
      if (busy === 1'b1) busys++;
      @(negedge aclk);
    end
    checks++;
    if (reqs != 0 || irqs != 0 || busys != 0) begin
      failures++;
      $display("FAIL reset_mid_abandon: req_cycles=%0d irq_cycles=%0d busy_cycles=%0d exp 0",
               reqs, irqs, busys);
    end
    checks++;
    if (rd_obs_q.size() != 1 || wr_obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_reqs: reads=%0d writes=%0d exp 1/0", rd_obs_q.size(), wr_obs_q.size());
    end
  endtask

  task automatic test_stall();
    run_xfer(32'h0000_A000, 32'h0000_B000, 1, 50, 1, 1'b0, "stall50");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      run_xfer($urandom, $urandom, $urandom_range(1, 5), $urandom_range(1, 4),
               $urandom_range(1, 4), 1'(k % 2), $sformatf("rand%0d", k));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    irq_clr = 1'b0; r_valid_tb = 1'b0;
    test_reset();
    test_basic();
    test_len_zero();
    test_align();
    test_start_ignored();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
